// File: rtl/pipe_ctl_fsm.sv
// Pipeline control FSM: decodes id_cmd into stall/flush/PC-select controls,
// with sized multicycle stalls and prioritised, maskable interrupts.
module pipe_ctl_fsm #(
    parameter int MUL_CYCLES = 33,
    parameter int DIV_CYCLES = 36,
    parameter int LD_STALL   = 1,
    parameter int NUM_IRQ    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic [2:0]         id_cmd,
    input  logic               md_done,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    output logic               iack,
    output logic [3:0]         irq_id,
    output logic               busy,
    output logic               zz_is_nop,
    output logic               id2ra_ins_clr,
    output logic               id2ra_ins_cls,
    output logic               id2ra_ctl_clr,
    output logic               id2ra_ctl_cls,
    output logic               ra2exec_ctl_clr,
    output logic [3:0]         pc_prectl
);

    localparam logic [3:0] PC_IGN = 4'b0001;
    localparam logic [3:0] PC_KEP = 4'b0010;
    localparam logic [3:0] PC_IRQ = 4'b0100;
    localparam logic [3:0] PC_RST = 4'b1000;

    localparam int MAX_MD = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int MAX_N  = (MAX_MD > LD_STALL) ? MAX_MD : LD_STALL;
    localparam int CW     = $clog2(MAX_N + 1);

    localparam logic [CW-1:0] MUL_LAST = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYCLES - 1);
    localparam logic [CW-1:0] LD_LAST  = CW'(LD_STALL - 1);

    typedef enum logic [3:0] {
        S_RST, S_IDLE, S_NOI, S_CUR, S_MUL, S_DIV, S_LD, S_IRQ, S_RET
    } state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cnt, cnt_nx;
    logic               iack_nx;
    logic [3:0]         irq_id_nx;
    logic [3:0]         pend_id;
    logic [NUM_IRQ-1:0] pend;

    assign pend = irq & irq_mask;

    // Scan downwards so the lowest pending index wins.
    always_comb begin
        pend_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) pend_id = 4'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_RST;
            cnt    <= '0;
            iack   <= 1'b0;
            irq_id <= 4'd0;
        end else if (!pause) begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            iack   <= iack_nx;
            irq_id <= irq_id_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        iack_nx   = iack;
        irq_id_nx = irq_id;
        unique case (state)
            S_RST: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
            S_IDLE, S_NOI: begin
                cnt_nx = '0;
                if ((|pend) && !iack) begin
                    state_nx  = S_IRQ;
                    irq_id_nx = pend_id;
                end else begin
                    unique case (id_cmd)
                        3'd1:    state_nx = S_CUR;
                        3'd2:    state_nx = S_MUL;
                        3'd3:    state_nx = S_LD;
                        3'd4:    state_nx = S_RET;
                        3'd5:    state_nx = S_DIV;
                        default: state_nx = S_NOI;
                    endcase
                end
            end
            S_CUR: state_nx = S_NOI;
            S_IRQ: begin
                state_nx = S_IDLE;
                iack_nx  = 1'b1;
            end
            S_RET: begin
                state_nx = S_IDLE;
                iack_nx  = 1'b0;
            end
            S_MUL: begin
                if (md_done || cnt == MUL_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_DIV: begin
                if (md_done || cnt == DIV_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_LD: begin
                if (cnt == LD_LAST) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = S_RST;
        endcase
    end

    // Moore output decode.
    always_comb begin
        id2ra_ins_clr   = 1'b0;
        id2ra_ins_cls   = 1'b0;
        id2ra_ctl_clr   = 1'b0;
        id2ra_ctl_cls   = 1'b0;
        ra2exec_ctl_clr = 1'b0;
        pc_prectl       = PC_IGN;
        zz_is_nop       = 1'b0;
        busy            = 1'b0;
        unique case (state)
            S_RST: begin
                id2ra_ins_clr   = 1'b1;
                id2ra_ctl_clr   = 1'b1;
                ra2exec_ctl_clr = 1'b1;
                pc_prectl       = PC_RST;
                zz_is_nop       = 1'b1;
            end
            S_CUR: begin
                id2ra_ins_cls   = 1'b1;
                id2ra_ctl_cls   = 1'b1;
                ra2exec_ctl_clr = 1'b1;
                pc_prectl       = PC_KEP;
                zz_is_nop       = 1'b1;
            end
            S_MUL, S_DIV, S_LD: begin
                id2ra_ins_clr = 1'b1;
                id2ra_ctl_clr = 1'b1;
                pc_prectl     = PC_KEP;
                busy          = 1'b1;
            end
            S_IRQ: begin
                id2ra_ins_clr   = 1'b1;
                id2ra_ctl_clr   = 1'b1;
                ra2exec_ctl_clr = 1'b1;
                pc_prectl       = PC_IRQ;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pipe_ctl_fsm.sv
// Directed bench for pipe_ctl_fsm; expected state/iack/irq_id are queued
// with each stimulus step and checked one cycle later.
module tb_pipe_ctl_fsm;

    typedef enum {
        E_RST, E_IDLE, E_NOI, E_CUR, E_MUL, E_DIV, E_LD, E_IRQ, E_RET
    } est_t;

    typedef struct {
        est_t       st;
        logic       iack;
        logic [3:0] id;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pause = 1'b0;
    logic [2:0] id_cmd = 3'd0;
    logic       md_done = 1'b0;
    logic [3:0] irq = 4'd0;
    logic [3:0] irq_mask = 4'd0;
    logic       iack;
    logic [3:0] irq_id;
    logic       busy;
    logic       zz_is_nop;
    logic       ins_clr, ins_cls, ctl_clr, ctl_cls, ex_clr;
    logic [3:0] pc_prectl;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t exp_q[$];

    pipe_ctl_fsm #(
        .MUL_CYCLES(33),
        .DIV_CYCLES(36),
        .LD_STALL(3),
        .NUM_IRQ(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pause(pause),
        .id_cmd(id_cmd),
        .md_done(md_done),
        .irq(irq),
        .irq_mask(irq_mask),
        .iack(iack),
        .irq_id(irq_id),
        .busy(busy),
        .zz_is_nop(zz_is_nop),
        .id2ra_ins_clr(ins_clr),
        .id2ra_ins_cls(ins_cls),
        .id2ra_ctl_clr(ctl_clr),
        .id2ra_ctl_cls(ctl_cls),
        .ra2exec_ctl_clr(ex_clr),
        .pc_prectl(pc_prectl)
    );

    always #5 clk = ~clk;

    // {ins_clr,ins_cls,ctl_clr,ctl_cls,ex_clr,pc[3:0],nop,busy}
    function automatic logic [10:0] row(input est_t s);
        case (s)
            E_RST:              return 11'b10101_1000_1_0;
            E_CUR:              return 11'b01011_0010_1_0;
            E_MUL, E_DIV, E_LD: return 11'b10100_0010_0_1;
            E_IRQ:              return 11'b10101_0100_0_0;
            default:            return 11'b00000_0001_0_0;
        endcase
    endfunction

    task automatic step(input logic [2:0] cmd, input est_t es,
                        input logic ei, input logic [3:0] eid,
                        input string tag);
        exp_t e;
        logic [10:0] obs;
        logic [10:0] want;
        exp_q.push_back('{es, ei, eid, tag});
        id_cmd = cmd;
        @(posedge clk);
        #1;
        e    = exp_q.pop_front();
        obs  = {ins_clr, ins_cls, ctl_clr, ctl_cls, ex_clr,
                pc_prectl, zz_is_nop, busy};
        want = row(e.st);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s row obs=%b exp=%b", e.tag, obs, want);
        end
        vectors++;
        assert (iack === e.iack) else begin
            miscompares++;
            $error("FAIL %s iack obs=%b exp=%b", e.tag, iack, e.iack);
        end
        vectors++;
        assert (irq_id === e.id) else begin
            miscompares++;
            $error("FAIL %s irq_id obs=%0d exp=%0d", e.tag, irq_id, e.id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        step(0, E_RST, 0, 0, "rst0");
        step(0, E_RST, 0, 0, "rst1");
        rst = 1'b0;
        step(0, E_IDLE, 0, 0, "rel");

        step(2, E_MUL, 0, 0, "mul");
        for (int i = 1; i < 33; i++) step(0, E_MUL, 0, 0, "mul");
        step(0, E_IDLE, 0, 0, "mul_end");

        step(5, E_DIV, 0, 0, "div");
        for (int i = 1; i < 5; i++) step(0, E_DIV, 0, 0, "div");
        md_done = 1'b1;
        step(0, E_IDLE, 0, 0, "div_done");
        md_done = 1'b0;

        irq = 4'b1010;
        irq_mask = 4'b1110;
        step(0, E_IRQ, 0, 1, "irq");
        step(0, E_IDLE, 1, 1, "irq_ack");
        step(0, E_NOI, 1, 1, "irq_busy");
        irq = 4'b0000;
        step(4, E_RET, 1, 1, "ret");
        step(0, E_IDLE, 0, 1, "ret_end");

        irq = 4'b1100;
        irq_mask = 4'b1111;
        step(0, E_IRQ, 0, 2, "prio2");
        step(0, E_IDLE, 1, 2, "prio2_ack");
        irq = 4'b0000;
        step(4, E_RET, 1, 2, "ret2");
        step(0, E_IDLE, 0, 2, "ret2_end");

        irq = 4'b0001;
        irq_mask = 4'b1110;
        step(0, E_NOI, 0, 2, "masked");
        irq = 4'b0000;
        irq_mask = 4'b0000;

        step(2, E_MUL, 0, 2, "pmul");
        for (int i = 1; i < 12; i++) step(0, E_MUL, 0, 2, "pmul");
        pause = 1'b1;
        md_done = 1'b1;
        for (int i = 0; i < 10; i++) step(0, E_MUL, 0, 2, "pmul_hold");
        pause = 1'b0;
        md_done = 1'b0;
        for (int i = 0; i < 21; i++) step(0, E_MUL, 0, 2, "pmul");
        step(0, E_IDLE, 0, 2, "pmul_end");

        step(2, E_MUL, 0, 2, "rmul");
        for (int i = 1; i < 12; i++) step(0, E_MUL, 0, 2, "rmul");
        pause = 1'b1;
        rst = 1'b1;
        step(0, E_RST, 0, 0, "rst_mul");
        pause = 1'b0;
        rst = 1'b0;
        step(0, E_IDLE, 0, 0, "rst_rel");

        step(3, E_LD, 0, 0, "ld");
        step(0, E_LD, 0, 0, "ld");
        step(0, E_LD, 0, 0, "ld");
        step(0, E_IDLE, 0, 0, "ld_end");

        step(1, E_CUR, 0, 0, "cur");
        irq = 4'b0001;
        irq_mask = 4'b0001;
        step(0, E_NOI, 0, 0, "cur_defer");
        step(0, E_IRQ, 0, 0, "irq0");
        step(0, E_IDLE, 1, 0, "irq0_ack");
        irq = 4'b0000;
        step(4, E_RET, 1, 0, "ret0");
        step(0, E_IDLE, 0, 0, "ret0_end");

        step(6, E_NOI, 0, 0, "code6");
        step(7, E_NOI, 0, 0, "code7");
        step(1, E_CUR, 0, 0, "cur2");
        pause = 1'b1;
        step(0, E_CUR, 0, 0, "pause_cur");
        pause = 1'b0;
        step(0, E_NOI, 0, 0, "cur2_end");

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
